// File: rtl/data_output.sv
`default_nettype none
// ============================================================================
// Module      : data_output
// Description : 64-entry word FIFO feeding an LSB-first serial shifter with
//               refill interrupt.
// Revision    : 1.0
// ============================================================================
module data_output #(
    parameter int WIDTH     = 24,
    parameter int DEPTH     = 64,
    parameter int THRESHOLD = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             bit_tick,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    output logic             serial,
    output logic             frame,
    output logic             rpi_interrupt,
    output logic [6:0]       level,
    output logic             full,
    output logic             overflow,
    output logic             underrun
);

    localparam int              c_AW         = $clog2(DEPTH);
    localparam int              c_BW         = $clog2(WIDTH);
    localparam logic [c_BW-1:0] c_LAST_BIT   = c_BW'(WIDTH - 1);
    localparam logic [6:0]      c_DEPTH_CNT  = 7'(DEPTH);
    localparam logic [6:0]      c_THRESH_CNT = 7'(THRESHOLD);

    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_SHIFT = 1'b1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [6:0]       r_count;
    logic [0:0]       r_state;
    logic [c_BW-1:0]  r_bit_cnt;
    logic [WIDTH-1:0] r_shreg;
    logic             r_serial;
    logic             r_frame;
    logic             r_irq;
    logic             r_full;
    logic             r_overflow;
    logic             r_underrun;

    logic [0:0]       w_state_nxt;
    logic             w_pop;
    logic             w_underrun_set;
    logic             w_write;
    logic             w_has_data;
    logic [WIDTH-1:0] w_head;
    logic             w_serial_nxt;
    logic             w_frame_nxt;
    logic [c_BW-1:0]  w_bit_cnt_nxt;
    logic [WIDTH-1:0] w_shreg_nxt;
    logic [6:0]       w_count_nxt;

    // Pop decisions use the pre-edge count, so a same-cycle write is never read.
    assign w_write    = load && !r_full;
    assign w_has_data = (r_count != 7'd0);
    assign w_head     = r_mem[r_rd_ptr];

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt    = r_state;
        w_pop          = 1'b0;
        w_underrun_set = 1'b0;
        if (!enable) begin
            w_state_nxt = c_ST_IDLE;
        end else if (bit_tick) begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_has_data) begin
                        w_pop       = 1'b1;
                        w_state_nxt = c_ST_SHIFT;
                    end
                end
                c_ST_SHIFT: begin
                    if (r_bit_cnt == c_LAST_BIT) begin
                        if (w_has_data) begin
                            w_pop = 1'b1;
                        end else begin
                            w_underrun_set = 1'b1;
                            w_state_nxt    = c_ST_IDLE;
                        end
                    end
                end
                default: w_state_nxt = c_ST_IDLE;
            endcase
        end
    end

    // Output / datapath logic
    always_comb begin
        w_serial_nxt  = r_serial;
        w_frame_nxt   = r_frame;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shreg_nxt   = r_shreg;
        if (!enable) begin
            w_serial_nxt = 1'b0;
            w_frame_nxt  = 1'b0;
        end else if (bit_tick) begin
            if (w_pop) begin
                w_shreg_nxt   = w_head;
                w_serial_nxt  = w_head[0];
                w_frame_nxt   = 1'b1;
                w_bit_cnt_nxt = '0;
            end else if (r_state == c_ST_SHIFT && !w_underrun_set) begin
                // Shift right so the next bit to send is always at index 1.
                w_shreg_nxt   = r_shreg >> 1;
                w_serial_nxt  = r_shreg[1];
                w_frame_nxt   = 1'b0;
                w_bit_cnt_nxt = r_bit_cnt + 1'b1;
            end else begin
                w_serial_nxt = 1'b0;
                w_frame_nxt  = 1'b0;
            end
        end
    end

    always_comb begin
        w_count_nxt = r_count;
        case ({w_write, w_pop})
            2'b10:   w_count_nxt = r_count + 7'd1;
            2'b01:   w_count_nxt = r_count - 7'd1;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_wr_ptr] <= data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_bit_cnt  <= '0;
            r_shreg    <= '0;
            r_serial   <= 1'b0;
            r_frame    <= 1'b0;
            r_irq      <= 1'b0;
            r_overflow <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count   <= w_count_nxt;
            r_full    <= (w_count_nxt == c_DEPTH_CNT);
            r_bit_cnt <= w_bit_cnt_nxt;
            r_shreg   <= w_shreg_nxt;
            r_serial  <= w_serial_nxt;
            r_frame   <= w_frame_nxt;
            r_irq     <= enable && (r_count < c_THRESH_CNT);
            if (load && r_full) begin
                r_overflow <= 1'b1;
            end
            if (w_underrun_set) begin
                r_underrun <= 1'b1;
            end
        end
    end

    assign serial        = r_serial;
    assign frame         = r_frame;
    assign rpi_interrupt = r_irq;
    assign level         = r_count;
    assign full          = r_full;
    assign overflow      = r_overflow;
    assign underrun      = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_data_output.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_output
// Description : Directed self-checking bench for data_output.
// Revision    : 1.0
// ============================================================================
module tb_data_output;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        bit_tick;
    logic        load;
    logic [23:0] data;
    logic        serial;
    logic        frame;
    logic        rpi_interrupt;
    logic [6:0]  level;
    logic        full;
    logic        overflow;
    logic        underrun;

    int vectors = 0;
    int errors  = 0;

    data_output dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .bit_tick      (bit_tick),
        .load          (load),
        .data          (data),
        .serial        (serial),
        .frame         (frame),
        .rpi_interrupt (rpi_interrupt),
        .level         (level),
        .full          (full),
        .overflow      (overflow),
        .underrun      (underrun)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    logic [23:0] word;
    logic [23:0] word2;
    logic [23:0] got [64];
    int          frame_err;
    int          lvl31_cyc;
    int          irq_cyc;

    initial begin
        reset = 1'b1; enable = 1'b0; bit_tick = 1'b0; load = 1'b0; data = '0;
        cyc(); cyc();
        reset = 1'b0;
        chk("rst_serial", serial, 0);
        chk("rst_frame", frame, 0);
        chk("rst_level", level, 0);
        chk("rst_flags", {rpi_interrupt, full, overflow, underrun}, 0);

        // Single word, tick every 4 cycles
        word = 24'hA5A5A5;
        load = 1'b1; data = word; cyc(); load = 1'b0;
        chk("single_level", level, 1);
        enable = 1'b1;
        for (int b = 0; b < 24; b++) begin
            bit_tick = 1'b1; cyc(); bit_tick = 1'b0;
            chk($sformatf("single_bit%0d", b), serial, word[b]);
            chk($sformatf("single_frame%0d", b), frame, (b == 0));
            cyc(); cyc(); cyc();
            chk($sformatf("single_hold%0d", b), {serial, frame}, {word[b], b == 0});
        end
        bit_tick = 1'b1; cyc(); bit_tick = 1'b0;
        chk("single_end_serial", serial, 0);
        chk("single_underrun", underrun, 1);

        // Reset mid-word
        do_reset();
        enable = 1'b1;
        load = 1'b1; data = 24'hABCDEF; cyc(); load = 1'b0;
        bit_tick = 1'b1;
        for (int i = 0; i < 11; i++) cyc();
        reset = 1'b1; load = 1'b1; data = 24'h777777; cyc();
        reset = 1'b0; load = 1'b0; bit_tick = 1'b0;
        chk("midrst_out", {serial, frame, rpi_interrupt, full, overflow, underrun}, 0);
        chk("midrst_level", level, 0);
        load = 1'b1; data = 24'h000001; cyc(); load = 1'b0;
        bit_tick = 1'b1;
        cyc(); chk("midrst_b0", {serial, frame}, 2'b11);
        cyc(); chk("midrst_b1", {serial, frame}, 2'b00);
        cyc(); chk("midrst_b2", {serial, frame}, 2'b00);
        bit_tick = 1'b0;

        // Back-to-back words at full rate
        do_reset();
        enable = 1'b1;
        load = 1'b1; data = 24'hFFFFFF; cyc();
        data = 24'h000000; cyc(); load = 1'b0;
        chk("b2b_level", level, 2);
        bit_tick = 1'b1;
        for (int i = 0; i < 48; i++) begin
            cyc();
            chk($sformatf("b2b_bit%0d", i), {serial, frame}, {i < 24, (i == 0) || (i == 24)});
        end
        chk("b2b_no_underrun_yet", underrun, 0);
        cyc();
        chk("b2b_underrun", {serial, underrun}, 2'b01);
        bit_tick = 1'b0;

        // Simultaneous load and pop
        do_reset();
        enable = 1'b0;
        load = 1'b1;
        for (int i = 0; i < 6; i++) begin
            data = 24'h100000 + 24'(i); cyc();
        end
        load = 1'b0;
        chk("sim_level6", level, 6);
        enable = 1'b1; bit_tick = 1'b1;
        cyc();
        chk("sim_level5", level, 5);
        for (int i = 0; i < 23; i++) cyc();
        load = 1'b1; data = 24'hAAAAAA; cyc(); load = 1'b0;
        chk("sim_boundary_level", level, 5);
        chk("sim_boundary_out", {serial, frame}, 2'b11);
        bit_tick = 1'b0;

        do_reset();
        enable = 1'b1;
        load = 1'b1; data = 24'h000003; bit_tick = 1'b1; cyc();
        load = 1'b0; bit_tick = 1'b0;
        chk("idle_load_nopop", {serial, frame}, 2'b00);
        chk("idle_load_level", level, 1);
        bit_tick = 1'b1; cyc(); bit_tick = 1'b0;
        chk("idle_next_tick", {serial, frame}, 2'b11);
        chk("idle_next_level", level, 0);

        // Fill, overflow, drain
        do_reset();
        enable = 1'b0;
        load = 1'b1;
        for (int i = 0; i < 65; i++) begin
            data = 24'hC30000 | 24'(i); cyc();
        end
        load = 1'b0;
        chk("fill_level", level, 64);
        chk("fill_flags", {full, overflow, rpi_interrupt}, 3'b110);
        enable = 1'b1; bit_tick = 1'b1;
        frame_err = 0; lvl31_cyc = -1; irq_cyc = -1;
        for (int c = 0; c < 64 * 24; c++) begin
            cyc();
            got[c / 24][c % 24] = serial;
            if (frame !== ((c % 24) == 0)) frame_err++;
            if (level == 7'd31 && lvl31_cyc < 0) lvl31_cyc = c;
            if (rpi_interrupt === 1'b1 && irq_cyc < 0) irq_cyc = c;
        end
        cyc();
        bit_tick = 1'b0;
        chk("drain_end", {serial, frame, level}, 0);
        chk("drain_underrun", underrun, 1);
        chk("drain_frame_errs", frame_err, 0);
        chk("lvl31_cycle", lvl31_cyc, 768);
        chk("irq_rise_cycle", irq_cyc, 769);
        for (int i = 0; i < 64; i++) begin
            word = 24'hC30000 | 24'(i);
            chk($sformatf("drain_word%0d", i), got[i], word);
        end

        // Enable drop mid-word
        do_reset();
        enable = 1'b0;
        word  = 24'h123456;
        word2 = 24'h654321;
        load = 1'b1; data = word; cyc();
        data = word2; cyc(); load = 1'b0;
        enable = 1'b1; bit_tick = 1'b1;
        for (int b = 0; b < 8; b++) begin
            cyc();
            chk($sformatf("drop_bit%0d", b), serial, word[b]);
        end
        bit_tick = 1'b0; enable = 1'b0; cyc();
        chk("drop_cleared", {serial, frame}, 2'b00);
        chk("drop_level", level, 1);
        enable = 1'b1; bit_tick = 1'b1;
        cyc();
        chk("reen_frame", {serial, frame}, {word2[0], 1'b1});
        for (int b = 1; b < 24; b++) begin
            cyc();
            chk($sformatf("reen_bit%0d", b), {serial, frame}, {word2[b], 1'b0});
        end
        cyc();
        bit_tick = 1'b0;
        chk("reen_no_resend", {serial, frame, level}, 0);
        chk("reen_underrun", underrun, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
